usb_tx_packetizer: RTL and testbench

USB_TX_PACKETIZER -- requirements
Module: usb_tx_packetizer

---
 rtl/usb_tx_packetizer.sv | 182 ++++++++++++++++++
 tb/tb_usb_tx_packetizer.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_tx_packetizer.sv
// USB transmit packetizer: frames SYNC, PID, optional payload and CRC16 into a
// byte stream for a serializer using a single-byte valid/ready handshake.
module usb_tx_packetizer (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [1:0] tx_packet_type,
    input  logic [6:0] buffer_occupancy,
    input  logic [7:0] tx_packet_data,
    output logic       get_tx_packet_data,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    input  logic       byte_ready,
    output logic       eop,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error
);

    typedef enum logic [3:0] {
        IDLE, SYNC, PID, FETCH, LOAD, DATA, CRC_LO, CRC_HI, EOP, DONE
    } state_t;

    localparam logic [6:0]  MAX_PAYLOAD = 7'd64;
    localparam logic [7:0]  SYNC_BYTE   = 8'h80;
    localparam logic [15:0] CRC_INIT    = 16'hFFFF;

    state_t      state_q;
    logic [1:0]  type_q;
    logic [6:0]  remain_q;
    logic [15:0] crc_q;
    logic [15:0] crc_d;
    logic [7:0]  byte_q;
    logic        valid_q;
    logic        get_q;
    logic        eop_q;
    logic        done_q;
    logic        error_q;
    logic        accept;

    // Reflected form of poly 0x8005 (0xA001), consuming the byte LSB first.
    function automatic logic [15:0] crc16_update(input logic [15:0] crc,
                                                 input logic [7:0]  data);
        logic [15:0] c;
        logic [7:0]  d;
        c = crc;
        d = data;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ d[0]) c = (c >> 1) ^ 16'hA001;
            else             c = c >> 1;
            d = d >> 1;
        end
        return c;
    endfunction

    function automatic logic [7:0] pid_byte(input logic [1:0] ptype);
        logic [7:0] pid;
        case (ptype)
            2'd0:    pid = 8'hC3;
            2'd1:    pid = 8'h4B;
            2'd2:    pid = 8'hD2;
            default: pid = 8'h5A;
        endcase
        return pid;
    endfunction

    assign accept = valid_q & byte_ready;
    assign crc_d  = crc16_update(crc_q, byte_q);

    assign get_tx_packet_data = get_q;
    assign byte_out           = byte_q;
    assign byte_valid         = valid_q;
    assign eop                = eop_q;
    assign tx_busy            = (state_q != IDLE);
    assign tx_done            = done_q;
    assign tx_error           = error_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            type_q   <= 2'd0;
            remain_q <= 7'd0;
            crc_q    <= CRC_INIT;
            byte_q   <= 8'h00;
            valid_q  <= 1'b0;
            get_q    <= 1'b0;
            eop_q    <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            get_q   <= 1'b0;
            eop_q   <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (tx_start) begin
                        // Only data packets carry a payload, so only they can overflow.
                        if (!tx_packet_type[1] && buffer_occupancy > MAX_PAYLOAD) begin
                            error_q <= 1'b1;
                        end else begin
                            type_q   <= tx_packet_type;
                            remain_q <= buffer_occupancy;
                            crc_q    <= CRC_INIT;
                            byte_q   <= SYNC_BYTE;
                            valid_q  <= 1'b1;
                            state_q  <= SYNC;
                        end
                    end
                end
                SYNC: begin
                    if (accept) begin
                        byte_q  <= pid_byte(type_q);
                        state_q <= PID;
                    end
                end
                PID: begin
                    if (accept) begin
                        if (type_q[1]) begin
                            valid_q <= 1'b0;
                            eop_q   <= 1'b1;
                            state_q <= EOP;
                        end else if (remain_q != 7'd0) begin
                            valid_q <= 1'b0;
                            get_q   <= 1'b1;
                            state_q <= FETCH;
                        end else begin
                            byte_q  <= ~crc_q[7:0];
                            state_q <= CRC_LO;
                        end
                    end
                end
                FETCH: begin
                    remain_q <= remain_q - 7'd1;
                    state_q  <= LOAD;
                end
                LOAD: begin
                    byte_q  <= tx_packet_data;
                    valid_q <= 1'b1;
                    state_q <= DATA;
                end
                DATA: begin
                    if (accept) begin
                        crc_q <= crc_d;
                        if (remain_q != 7'd0) begin
                            valid_q <= 1'b0;
                            get_q   <= 1'b1;
                            state_q <= FETCH;
                        end else begin
                            byte_q  <= ~crc_d[7:0];
                            state_q <= CRC_LO;
                        end
                    end
                end
                CRC_LO: begin
                    if (accept) begin
                        byte_q  <= ~crc_q[15:8];
                        state_q <= CRC_HI;
                    end
                end
                CRC_HI: begin
                    if (accept) begin
                        valid_q <= 1'b0;
                        eop_q   <= 1'b1;
                        state_q <= EOP;
                    end
                end
                EOP: begin
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_usb_tx_packetizer.sv
// Directed testbench for usb_tx_packetizer: a negedge monitor logs accepted
// bytes and strobes while per-scenario tasks compare against expected values.
module tb_usb_tx_packetizer;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_start;
    logic [1:0] tx_packet_type;
    logic [6:0] buffer_occupancy;
    logic [7:0] tx_packet_data;
    logic       get_tx_packet_data;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       byte_ready;
    logic       eop;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_error;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;

    logic [7:0] mem [0:63];
    bit         rand_ready = 1'b0;
    int         clr_gen = 0;

    // Monitor-owned log
    int         seen_gen = 0;
    logic [7:0] got [$];
    int         rd_idx = 0;
    int         get_cnt = 0, eop_cnt = 0, done_cnt = 0, err_cnt = 0, stall_viol = 0;
    int         last_byte_cyc = -1, eop_cyc = -1, done_cyc = -1;
    bit         busy_seen = 1'b0;
    bit         prev_get = 1'b0, prev_stall = 1'b0, prev_rst = 1'b1;
    logic [7:0] prev_byte = 8'h00;

    always #5 clk = ~clk;

    usb_tx_packetizer dut (
        .clk                (clk),
        .rst                (rst),
        .tx_start           (tx_start),
        .tx_packet_type     (tx_packet_type),
        .buffer_occupancy   (buffer_occupancy),
        .tx_packet_data     (tx_packet_data),
        .get_tx_packet_data (get_tx_packet_data),
        .byte_out           (byte_out),
        .byte_valid         (byte_valid),
        .byte_ready         (byte_ready),
        .eop                (eop),
        .tx_busy            (tx_busy),
        .tx_done            (tx_done),
        .tx_error           (tx_error)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Buffer model presents read data only in the cycle after the strobe.
    always @(negedge clk) begin
        if (clr_gen != seen_gen) begin
            seen_gen = clr_gen;
            got.delete();
            rd_idx = 0; get_cnt = 0; eop_cnt = 0; done_cnt = 0; err_cnt = 0; stall_viol = 0;
            last_byte_cyc = -1; eop_cyc = -1; done_cyc = -1; busy_seen = 1'b0;
        end
        if (prev_get) begin
            tx_packet_data = mem[rd_idx % 64];
            rd_idx++;
        end else begin
            tx_packet_data = 8'hEE;
        end
        if (!rst) begin
            if (prev_stall && !prev_rst && (byte_valid !== 1'b1 || byte_out !== prev_byte))
                stall_viol++;
            if (byte_valid === 1'b1 && byte_ready === 1'b1) begin
                got.push_back(byte_out);
                last_byte_cyc = cyc;
            end
            if (get_tx_packet_data === 1'b1) get_cnt++;
            if (eop === 1'b1) begin eop_cnt++; eop_cyc = cyc; end
            if (tx_done === 1'b1) begin done_cnt++; done_cyc = cyc; end
            if (tx_error === 1'b1) err_cnt++;
            if (tx_busy === 1'b1) busy_seen = 1'b1;
        end
        prev_get   = (get_tx_packet_data === 1'b1) && !rst;
        prev_stall = (byte_valid === 1'b1) && (byte_ready !== 1'b1);
        prev_byte  = byte_out;
        prev_rst   = rst;
    end

    // Reference CRC: non-reflected shift-left register fed bit-reversed data.
    function automatic logic [15:0] ref_crc(input int n);
        logic [15:0] r;
        logic [15:0] rev;
        logic [7:0]  d;
        logic        fb;
        r = 16'hFFFF;
        for (int k = 0; k < n; k++) begin
            d = mem[k];
            for (int b = 0; b < 8; b++) begin
                fb = r[15] ^ d[0];
                r  = {r[14:0], 1'b0};
                if (fb) r = r ^ 16'h8005;
                d = d >> 1;
            end
        end
        for (int b = 0; b < 16; b++) rev[b] = r[15-b];
        return ~rev;
    endfunction

    task automatic clear_log();
        clr_gen++;
    endtask

    task automatic start_pkt(input logic [1:0] t, input logic [6:0] occ);
        tx_packet_type   = t;
        buffer_occupancy = occ;
        tx_start         = 1'b1;
        @(posedge clk); #1;
        tx_start         = 1'b0;
        tx_packet_type   = ~t;
        buffer_occupancy = 7'h7F;
    endtask

    task automatic wait_done(input int budget, output bit timed_out);
        int n;
        n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(posedge clk); #1;
            if (rand_ready) byte_ready = 1'($urandom_range(0, 1));
            n++;
        end
        timed_out = (done_cnt == 0);
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; tx_start = 1'b1; tx_packet_type = 2'd0; buffer_occupancy = 7'd1; byte_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        nvec++; if (byte_out !== 8'h00) begin nerr++; $display("FAIL reset_byte_out got=%h want=00", byte_out); end
        nvec++; if (byte_valid !== 1'b0) begin nerr++; $display("FAIL reset_byte_valid got=%b want=0", byte_valid); end
        nvec++; if (get_tx_packet_data !== 1'b0) begin nerr++; $display("FAIL reset_get got=%b want=0", get_tx_packet_data); end
        nvec++; if (eop !== 1'b0) begin nerr++; $display("FAIL reset_eop got=%b want=0", eop); end
        nvec++; if (tx_done !== 1'b0) begin nerr++; $display("FAIL reset_done got=%b want=0", tx_done); end
        nvec++; if (tx_error !== 1'b0) begin nerr++; $display("FAIL reset_error got=%b want=0", tx_error); end
        nvec++; if (tx_busy !== 1'b0) begin nerr++; $display("FAIL reset_busy got=%b want=0", tx_busy); end
        tx_start = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        nvec++; if (tx_busy !== 1'b0) begin nerr++; $display("FAIL reset_release_busy got=%b want=0", tx_busy); end
    endtask

    task automatic test_ack();
        bit to;
        logic [7:0] exp [$];
        clear_log(); rand_ready = 1'b0; byte_ready = 1'b1;
        start_pkt(2'd2, 7'd100);
        nvec++; if (byte_valid !== 1'b1 || byte_out !== 8'h80 || tx_busy !== 1'b1) begin
            nerr++; $display("FAIL ack_sync_cycle got valid=%b byte=%h busy=%b want 1/80/1", byte_valid, byte_out, tx_busy);
        end
        wait_done(50, to);
        exp = '{8'h80, 8'hD2};
        nvec++; if (to) begin nerr++; $display("FAIL ack_timeout got=no tx_done want=tx_done"); end
        nvec++; if (got.size() != exp.size()) begin nerr++; $display("FAIL ack_len got=%0d want=%0d", got.size(), exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            nvec++; if (got[i] !== exp[i]) begin nerr++; $display("FAIL ack_byte%0d got=%h want=%h", i, got[i], exp[i]); end
        end
        nvec++; if (get_cnt != 0) begin nerr++; $display("FAIL ack_gets got=%0d want=0", get_cnt); end
        nvec++; if (err_cnt != 0) begin nerr++; $display("FAIL ack_error got=%0d want=0", err_cnt); end
        nvec++; if (eop_cnt != 1 || eop_cyc != last_byte_cyc + 1) begin
            nerr++; $display("FAIL ack_eop got cnt=%0d cyc=%0d want cnt=1 cyc=%0d", eop_cnt, eop_cyc, last_byte_cyc + 1);
        end
        nvec++; if (done_cnt != 1 || done_cyc != eop_cyc + 1) begin
            nerr++; $display("FAIL ack_done got cnt=%0d cyc=%0d want cnt=1 cyc=%0d", done_cnt, done_cyc, eop_cyc + 1);
        end
        nvec++; if (tx_busy !== 1'b0) begin nerr++; $display("FAIL ack_idle_busy got=%b want=0", tx_busy); end
    endtask

    task automatic test_data1_empty();
        bit to;
        logic [7:0] exp [$];
        clear_log(); rand_ready = 1'b0; byte_ready = 1'b1;
        start_pkt(2'd1, 7'd0);
        wait_done(50, to);
        exp = '{8'h80, 8'h4B, 8'h00, 8'h00};
        nvec++; if (to) begin nerr++; $display("FAIL empty_timeout got=no tx_done want=tx_done"); end
        nvec++; if (got.size() != exp.size()) begin nerr++; $display("FAIL empty_len got=%0d want=%0d", got.size(), exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            nvec++; if (got[i] !== exp[i]) begin nerr++; $display("FAIL empty_byte%0d got=%h want=%h", i, got[i], exp[i]); end
        end
        nvec++; if (get_cnt != 0) begin nerr++; $display("FAIL empty_gets got=%0d want=0", get_cnt); end
        nvec++; if (eop_cnt != 1 || eop_cyc != last_byte_cyc + 1) begin
            nerr++; $display("FAIL empty_eop got cnt=%0d cyc=%0d want cnt=1 cyc=%0d", eop_cnt, eop_cyc, last_byte_cyc + 1);
        end
        nvec++; if (done_cnt != 1 || done_cyc != eop_cyc + 1) begin
            nerr++; $display("FAIL empty_done got cnt=%0d cyc=%0d want cnt=1 cyc=%0d", done_cnt, done_cyc, eop_cyc + 1);
        end
    endtask

    task automatic test_data0_four();
        bit to;
        logic [15:0] crc;
        logic [7:0] exp [$];
        clear_log(); rand_ready = 1'b0; byte_ready = 1'b1;
        mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03; mem[3] = 8'h04;
        crc = ref_crc(4);
        start_pkt(2'd0, 7'd4);
        wait_done(100, to);
        exp = '{8'h80, 8'hC3, 8'h01, 8'h02, 8'h03, 8'h04, crc[7:0], crc[15:8]};
        nvec++; if (to) begin nerr++; $display("FAIL four_timeout got=no tx_done want=tx_done"); end
        nvec++; if (got.size() != exp.size()) begin nerr++; $display("FAIL four_len got=%0d want=%0d", got.size(), exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            nvec++; if (got[i] !== exp[i]) begin nerr++; $display("FAIL four_byte%0d got=%h want=%h", i, got[i], exp[i]); end
        end
        nvec++; if (get_cnt != 4) begin nerr++; $display("FAIL four_gets got=%0d want=4", get_cnt); end
    endtask

    task automatic test_crc_check();
        bit to;
        logic [7:0] exp [$];
        clear_log(); rand_ready = 1'b0; byte_ready = 1'b1;
        for (int i = 0; i < 9; i++) mem[i] = 8'(8'h31 + i);
        start_pkt(2'd1, 7'd9);
        wait_done(150, to);
        exp = '{8'h80, 8'h4B, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'hC8, 8'hB4};
        nvec++; if (to) begin nerr++; $display("FAIL check_timeout got=no tx_done want=tx_done"); end
        nvec++; if (got.size() != exp.size()) begin nerr++; $display("FAIL check_len got=%0d want=%0d", got.size(), exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            nvec++; if (got[i] !== exp[i]) begin nerr++; $display("FAIL check_byte%0d got=%h want=%h", i, got[i], exp[i]); end
        end
    endtask

    task automatic test_full_stall();
        bit to;
        logic [15:0] crc;
        logic [7:0] exp [$];
        clear_log(); rand_ready = 1'b1; byte_ready = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
        crc = ref_crc(64);
        exp = '{8'h80, 8'hC3};
        for (int i = 0; i < 64; i++) exp.push_back(mem[i]);
        exp.push_back(crc[7:0]);
        exp.push_back(crc[15:8]);
        start_pkt(2'd0, 7'd64);
        wait_done(3000, to);
        rand_ready = 1'b0; byte_ready = 1'b1;
        nvec++; if (to) begin nerr++; $display("FAIL full_timeout got=no tx_done want=tx_done"); end
        nvec++; if (got.size() != exp.size()) begin nerr++; $display("FAIL full_len got=%0d want=%0d", got.size(), exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            nvec++; if (got[i] !== exp[i]) begin nerr++; $display("FAIL full_byte%0d got=%h want=%h", i, got[i], exp[i]); end
        end
        nvec++; if (get_cnt != 64) begin nerr++; $display("FAIL full_gets got=%0d want=64", get_cnt); end
        nvec++; if (stall_viol != 0) begin nerr++; $display("FAIL full_stall_hold got=%0d violations want=0", stall_viol); end
        nvec++; if (eop_cnt != 1 || done_cnt != 1) begin
            nerr++; $display("FAIL full_end got eop=%0d done=%0d want 1/1", eop_cnt, done_cnt);
        end
    endtask

    task automatic test_oversize();
        clear_log(); rand_ready = 1'b0; byte_ready = 1'b1;
        start_pkt(2'd0, 7'd65);
        repeat (5) @(posedge clk);
        #1;
        nvec++; if (err_cnt != 1) begin nerr++; $display("FAIL over_error got=%0d cycles want=1", err_cnt); end
        nvec++; if (busy_seen != 1'b0) begin nerr++; $display("FAIL over_busy got=%b want=0", busy_seen); end
        nvec++; if (got.size() != 0) begin nerr++; $display("FAIL over_bytes got=%0d want=0", got.size()); end
        nvec++; if (get_cnt != 0 || eop_cnt != 0 || done_cnt != 0) begin
            nerr++; $display("FAIL over_strobes got get=%0d eop=%0d done=%0d want 0/0/0", get_cnt, eop_cnt, done_cnt);
        end
    endtask

    task automatic test_reset_mid_packet();
        bit to;
        bit stray_sent;
        int n;
        logic [7:0] exp [$];
        clear_log(); rand_ready = 1'b0; byte_ready = 1'b1;
        for (int i = 0; i < 64; i++) mem[i] = 8'(i * 7 + 3);
        start_pkt(2'd0, 7'd32);
        n = 0; stray_sent = 1'b0;
        while (!(got.size() == 11 && byte_valid === 1'b1) && n < 400) begin
            @(posedge clk); #1; n++;
            if (got.size() == 5 && !stray_sent) begin
                tx_start = 1'b1; tx_packet_type = 2'd2; stray_sent = 1'b1;
            end else begin
                tx_start = 1'b0;
            end
        end
        tx_start = 1'b0;
        nvec++; if (n >= 400) begin nerr++; $display("FAIL midrst_reach_byte10 got=timeout want=byte 10 presented"); end
        rst = 1'b1;
        @(posedge clk); #1;
        nvec++; if (byte_out !== 8'h00 || byte_valid !== 1'b0 || get_tx_packet_data !== 1'b0) begin
            nerr++; $display("FAIL midrst_data_outs got byte=%h valid=%b get=%b want 00/0/0", byte_out, byte_valid, get_tx_packet_data);
        end
        nvec++; if (eop !== 1'b0 || tx_done !== 1'b0 || tx_error !== 1'b0 || tx_busy !== 1'b0) begin
            nerr++; $display("FAIL midrst_ctrl_outs got eop=%b done=%b err=%b busy=%b want 0/0/0/0", eop, tx_done, tx_error, tx_busy);
        end
        exp = '{8'h80, 8'hC3};
        for (int i = 0; i < 9; i++) exp.push_back(mem[i]);
        nvec++; if (got.size() != exp.size()) begin nerr++; $display("FAIL midrst_len got=%0d want=%0d", got.size(), exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            nvec++; if (got[i] !== exp[i]) begin nerr++; $display("FAIL midrst_byte%0d got=%h want=%h", i, got[i], exp[i]); end
        end
        nvec++; if (get_cnt != 10) begin nerr++; $display("FAIL midrst_gets got=%0d want=10", get_cnt); end
        rst = 1'b0;
        clear_log();
        repeat (6) @(posedge clk);
        #1;
        nvec++; if (busy_seen != 1'b0 || got.size() != 0 || get_cnt != 0) begin
            nerr++; $display("FAIL midrst_no_resume got busy=%b bytes=%0d gets=%0d want 0/0/0", busy_seen, got.size(), get_cnt);
        end
        clear_log();
        start_pkt(2'd3, 7'd0);
        wait_done(50, to);
        exp = '{8'h80, 8'h5A};
        nvec++; if (to) begin nerr++; $display("FAIL nak_timeout got=no tx_done want=tx_done"); end
        nvec++; if (got.size() != exp.size()) begin nerr++; $display("FAIL nak_len got=%0d want=%0d", got.size(), exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            nvec++; if (got[i] !== exp[i]) begin nerr++; $display("FAIL nak_byte%0d got=%h want=%h", i, got[i], exp[i]); end
        end
    endtask

    initial begin
        rst = 1'b1;
        tx_start = 1'b0;
        tx_packet_type = 2'd0;
        buffer_occupancy = 7'd0;
        byte_ready = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = 8'h00;
        test_reset();
        test_ack();
        test_data1_empty();
        test_data0_four();
        test_crc_check();
        test_full_stall();
        test_oversize();
        test_reset_mid_packet();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
